// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the systolic MAC processing element.
//   pe_state_t : tile framing FSM state (IDLE = no tile open, ACCUM = tile
//                in progress).
//   satMax/satMin : clamp limits for an accumulator of a given width and
//                signedness, returned at PE_MAX_ACC_WIDTH bits so that any
//                accumulator up to that width can take its low bits.
// ---------------------------------------------------------------------------
package pe_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pe_state_t;

    localparam int PE_MAX_ACC_WIDTH = 128;

    // Largest representable accumulator value: 0111..1 for signed,
    // 1111..1 for unsigned.
    function automatic logic [PE_MAX_ACC_WIDTH-1:0] satMax(input int accWidth,
                                                           input bit isSigned);
        logic [PE_MAX_ACC_WIDTH-1:0] one;
        one = {{(PE_MAX_ACC_WIDTH-1){1'b0}}, 1'b1};
        if (isSigned) begin
            return (one << (accWidth - 1)) - one;
        end
        return (one << accWidth) - one;
    endfunction

    // Smallest representable accumulator value: 1000..0 for signed, 0 for
    // unsigned.
    function automatic logic [PE_MAX_ACC_WIDTH-1:0] satMin(input int accWidth,
                                                           input bit isSigned);
        logic [PE_MAX_ACC_WIDTH-1:0] one;
        one = {{(PE_MAX_ACC_WIDTH-1){1'b0}}, 1'b1};
        if (isSigned) begin
            return one << (accWidth - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/pe_sat_add.sv
// ---------------------------------------------------------------------------
// pe_sat_add
// Combinational accumulator adder with overflow detection and optional
// saturation.
//   i_a, i_b    : ACC_WIDTH addends (two's complement when SIGNED=1)
//   o_sum       : truncated sum, or the clamped limit when SATURATE=1 and the
//                 addition overflowed
//   o_overflow  : the true sum does not fit in ACC_WIDTH bits
// ---------------------------------------------------------------------------
module pe_sat_add
    import pe_pkg::*;
#(
    parameter int ACC_WIDTH = 40,
    parameter int SIGNED    = 0,
    parameter int SATURATE  = 0
) (
    input  logic [ACC_WIDTH-1:0] i_a,
    input  logic [ACC_WIDTH-1:0] i_b,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_overflow
);

    localparam logic [PE_MAX_ACC_WIDTH-1:0] SAT_MAX_FULL = satMax(ACC_WIDTH, SIGNED != 0);
    localparam logic [PE_MAX_ACC_WIDTH-1:0] SAT_MIN_FULL = satMin(ACC_WIDTH, SIGNED != 0);
    localparam logic [ACC_WIDTH-1:0]        SAT_MAX      = SAT_MAX_FULL[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0]        SAT_MIN      = SAT_MIN_FULL[ACC_WIDTH-1:0];

    // One extra bit keeps the unsigned carry out.
    logic [ACC_WIDTH:0] w_wide;
    logic               w_overflow;

    assign w_wide = {1'b0, i_a} + {1'b0, i_b};

    // Signed overflow: equal-sign addends producing a result of the other
    // sign. Unsigned overflow: carry out of the top bit.
    always_comb begin
        w_overflow = 1'b0;
        if (SIGNED != 0) begin
            w_overflow = (i_a[ACC_WIDTH-1] == i_b[ACC_WIDTH-1]) &&
                         (w_wide[ACC_WIDTH-1] != i_a[ACC_WIDTH-1]);
        end else begin
            w_overflow = w_wide[ACC_WIDTH];
        end
    end

    // On signed overflow both addends share a sign, so i_a's sign bit says
    // which rail to clamp to. Unsigned can only overflow upward.
    always_comb begin
        o_sum = w_wide[ACC_WIDTH-1:0];
        if ((SATURATE != 0) && w_overflow) begin
            if ((SIGNED != 0) && i_a[ACC_WIDTH-1]) begin
                o_sum = SAT_MIN;
            end else begin
                o_sum = SAT_MAX;
            end
        end
    end

    assign o_overflow = w_overflow;

endmodule

// File: rtl/pe_mac_cell.sv
// ---------------------------------------------------------------------------
// pe_mac_cell
// Systolic multiply-accumulate processing element.
//   clk, reset        : clock, synchronous active-high reset
//   pause             : freezes forwarding registers and the accumulator
//   left_in, top_in   : row / column operands
//   valid_in, last_in : operand valid, final beat of a tile
//   right_out, bottom_out, valid_out, last_out : inputs forwarded 1 cycle later
//   result, result_valid, result_ready : completed tile sum with handshake
//   overflow          : sticky, accumulator overflowed since reset
//   overrun           : sticky, an unconsumed result was overwritten
// ---------------------------------------------------------------------------
module pe_mac_cell
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int SIGNED     = 0,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pause,
    input  logic [DATA_WIDTH-1:0] left_in,
    input  logic [DATA_WIDTH-1:0] top_in,
    input  logic                  valid_in,
    input  logic                  last_in,
    output logic [DATA_WIDTH-1:0] right_out,
    output logic [DATA_WIDTH-1:0] bottom_out,
    output logic                  valid_out,
    output logic                  last_out,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  overflow,
    output logic                  overrun
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    pe_state_t r_state;
    pe_state_t w_nextState;

    logic [DATA_WIDTH-1:0] r_rightOut;
    logic [DATA_WIDTH-1:0] r_bottomOut;
    logic                  r_validOut;
    logic                  r_lastOut;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [ACC_WIDTH-1:0]  r_result;
    logic                  r_resultValid;
    logic                  r_overflow;
    logic                  r_overrun;

    logic                  w_beat;
    logic                  w_accLoad;
    logic                  w_accClear;
    logic                  w_tileClose;
    logic [PROD_WIDTH-1:0] w_leftExt;
    logic [PROD_WIDTH-1:0] w_topExt;
    logic [PROD_WIDTH-1:0] w_prod;
    logic [ACC_WIDTH-1:0]  w_addend;
    logic [ACC_WIDTH-1:0]  w_sum;
    logic                  w_sumOverflow;

    // pause wins over valid_in.
    assign w_beat = valid_in & ~pause;

    // Extending both operands to 2*DATA_WIDTH and keeping the low half of
    // the product gives the exact signed or unsigned product.
    assign w_leftExt = {{DATA_WIDTH{(SIGNED != 0) & left_in[DATA_WIDTH-1]}}, left_in};
    assign w_topExt  = {{DATA_WIDTH{(SIGNED != 0) & top_in[DATA_WIDTH-1]}},  top_in};
    assign w_prod    = w_leftExt * w_topExt;

    generate
        if (ACC_WIDTH > PROD_WIDTH) begin : g_prodExtend
            assign w_addend = {{(ACC_WIDTH-PROD_WIDTH){(SIGNED != 0) & w_prod[PROD_WIDTH-1]}},
                               w_prod};
        end else begin : g_prodDirect
            assign w_addend = w_prod;
        end
    endgenerate

    // The accumulator is always 0 in IDLE, so one adder covers both opening
    // a tile and continuing it.
    pe_sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .SIGNED    (SIGNED),
        .SATURATE  (SATURATE)
    ) u_satAdd (
        .i_a        (r_acc),
        .i_b        (w_addend),
        .o_sum      (w_sum),
        .o_overflow (w_sumOverflow)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a non-last beat opens or continues a tile; a last beat
    // always leaves the FSM in IDLE.
    always_comb begin
        w_nextState = r_state;
        if (w_beat) begin
            case (r_state)
                IDLE:    if (!last_in) w_nextState = ACCUM;
                ACCUM:   if (last_in)  w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Datapath controls. A last beat closes the tile in either state; in
    // IDLE that is a single-beat tile whose result is just the product.
    always_comb begin
        w_accLoad   = 1'b0;
        w_accClear  = 1'b0;
        w_tileClose = 1'b0;
        if (w_beat) begin
            if (last_in) begin
                w_tileClose = 1'b1;
                w_accClear  = 1'b1;
            end else begin
                w_accLoad = 1'b1;
            end
        end
    end

    // Forwarding registers pass operands through regardless of valid_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rightOut  <= '0;
            r_bottomOut <= '0;
            r_validOut  <= 1'b0;
            r_lastOut   <= 1'b0;
        end else if (!pause) begin
            r_rightOut  <= left_in;
            r_bottomOut <= top_in;
            r_validOut  <= valid_in;
            r_lastOut   <= last_in;
        end
    end

    // Accumulator and sticky overflow, both only advanced by a beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accClear) begin
                r_acc <= '0;
            end else if (w_accLoad) begin
                r_acc <= w_sum;
            end
            if (w_beat && w_sumOverflow) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Result holding register. A tile close always loads and keeps valid
    // high; it is an overrun only if the old result was not taken this cycle.
    // The handshake ignores pause.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result      <= '0;
            r_resultValid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_tileClose) begin
                r_result      <= w_sum;
                r_resultValid <= 1'b1;
                if (r_resultValid && !result_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_resultValid && result_ready) begin
                r_resultValid <= 1'b0;
            end
        end
    end

    assign right_out    = r_rightOut;
    assign bottom_out   = r_bottomOut;
    assign valid_out    = r_validOut;
    assign last_out     = r_lastOut;
    assign result       = r_result;
    assign result_valid = r_resultValid;
    assign overflow     = r_overflow;
    assign overrun      = r_overrun;

endmodule

// File: doc/pe_mac_cell.md
Name: pe_mac_cell

Overview:
- Parametrised systolic processing element for the tensor-core compute array. It is the successor to the fixed 16-bit edge PE.
- Multiplies left/top operands, accumulates into a wider accumulator, and forwards operands plus valid/last sideband one cycle downstream.
- Provides per-tile framing via a last flag, a result holding register with valid/ready handshake, optional signed and saturating arithmetic, and sticky overflow/overrun status.

Parameters:
- DATA_WIDTH, 16, operand width in bits.
- ACC_WIDTH, 40, accumulator width in bits. Must be >= 2*DATA_WIDTH.
- SIGNED, 0, 1 = operands and accumulator are two's complement; 0 = unsigned.
- SATURATE, 0, 1 = clamp the accumulator on overflow; 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pause  in  1  freezes forwarding registers and the accumulator.
- left_in  in  DATA_WIDTH  row operand.
- top_in  in  DATA_WIDTH  column operand.
- valid_in  in  1  operands are valid this cycle.
- last_in  in  1  this valid beat is the final beat of a tile; qualified by valid_in.
- right_out  out  DATA_WIDTH  registered left_in.
- bottom_out  out  DATA_WIDTH  registered top_in.
- valid_out  out  1  registered valid_in.
- last_out  out  1  registered last_in.
- result  out  ACC_WIDTH  completed tile sum held in the holding register.
- result_valid  out  1  result holds an unconsumed tile sum.
- result_ready  in  1  consumer accepts result this cycle.
- overflow  out  1  sticky flag: the accumulator overflowed in some tile since reset.
- overrun  out  1  sticky flag: an unconsumed result was overwritten.

Behaviour:
- Reset (synchronous, active-high) zeroes every register:
  - outputs right_out, bottom_out, valid_out, last_out, result, result_valid, overflow, overrun all read 0;
  - accumulator = 0;
  - FSM returns to IDLE.
  - Reset mid-tile discards the partial sum.
- Forwarding path:
  - Latency is 1 cycle.
  - When pause=0: right_out<=left_in, bottom_out<=top_in, valid_out<=valid_in, last_out<=last_in.
  - When pause=1: all four hold their values.
  - Forwarding ignores valid_in; operands pass through even when invalid.
- Product:
  - prod = left_in*top_in at full 2*DATA_WIDTH width.
  - Sign-extended when SIGNED=1, zero-extended otherwise, to ACC_WIDTH.
- Beat definition: beat = valid_in & ~pause. pause has priority over valid_in.
- FSM states:
  - IDLE: accumulator holds 0.
  - ACCUM: a tile is in progress.
- Transitions on a beat:
  - IDLE, last_in=0: acc<=prod; go to ACCUM.
  - IDLE, last_in=1: single-beat tile. The product is captured straight into result; acc stays 0; stay in IDLE.
  - ACCUM, last_in=0: acc<=acc+prod; stay in ACCUM.
  - ACCUM, last_in=1: result<=acc+prod; acc<=0; go to IDLE.
  - No beat: hold state.
- Arithmetic:
  - The sum is computed at ACC_WIDTH+1 bits.
  - Overflow when SIGNED=1: both operands have equal sign and the sum sign differs.
  - Overflow when SIGNED=0: carry out of ACC_WIDTH.
  - SATURATE=1: clamp to the max or min representable value (unsigned min = 0 is unreachable).
  - SATURATE=0: truncate.
  - Any overflow sets the sticky overflow flag in either mode; only reset clears it.
- Result handshake:
  - result_valid rises the cycle after the tile-closing beat.
  - It falls the cycle after result_valid & result_ready.
  - result is stable while result_valid=1 and not consumed.
- Simultaneous consume and tile close in the same cycle: the new result loads, result_valid stays 1, overrun is not set.
- Tile close while result_valid=1 and result_ready=0: the new result overwrites the old one, result_valid stays 1, and overrun is set (sticky until reset).
- pause does not block the result handshake. Consumption proceeds during pause.

Decomposition:
- Shared package pe_pkg:
  - FSM state enum pe_state_t {IDLE, ACCUM};
  - localparams for the saturation max/min derived from ACC_WIDTH and SIGNED.
- Sub-module pe_sat_add: combinational ACC_WIDTH adder returning sum and overflow, with SIGNED/SATURATE parameters.
- Forwarding registers and the FSM stay inline.

Test Plan:
1. Defaults. Three beats (2×3, 4×5, 6×7), last on the third → result_valid rises the next cycle with result=68. With result_ready=1 it falls one cycle later. right_out/bottom_out track inputs with a 1-cycle delay.
2. pause=1 held for 2 cycles mid-tile with valid_in=1 → accumulator and forwarding outputs frozen; the final result excludes the paused beats.
3. SIGNED=1, DATA_WIDTH=8, ACC_WIDTH=16. Beats (-128×-128) ×3 → 16384+16384 overflows. With SATURATE=1: result=32767, overflow=1. With SATURATE=0: the wrapped value, with overflow=1.
4. result_ready=0. Close tile A=10, then tile B=20 → result=20, overrun=1. Then asserting result_ready clears result_valid; overrun stays 1.
5. result_ready asserted in the same cycle as a tile close → result switches to the new value, result_valid stays 1, overrun=0.
6. reset asserted mid-tile after 2 beats → all outputs 0 the next cycle. A subsequent single-beat tile (5×5, last) gives result=25, with no stale partial sum included.
